instr_mem_arbiter: RTL

- Two-master arbiter in front of one single-port 256x32 instruction RAM. The RAM has a synchronous address/data register and an unregistered output, so read data is valid one cycle after the access.
- Master 0 is the soft-core instruction-fetch port (read-only). Master 1 is the host/loader port (read/write with byte enables).
- The arbiter issues at most one RAM access per cycle, returns read data to the correct master with a fixed 1-cycle latency, and lets the loader lock out fetches while it reprograms the memory.

---
 rtl/instr_mem_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/instr_mem_arbiter.sv
// Two-master arbiter in front of a single-port instruction RAM with a registered
// address/data stage. Master 0 fetches, master 1 loads; read data returns after one cycle.
module instr_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic granted;
  logic rd_issue;

  logic last_grant_q, last_grant_d;
  logic rd_valid_q,   rd_valid_d;
  logic rd_owner_q,   rd_owner_d;

  always_comb begin
    req0 = m0_read;
    req1 = m1_read | m1_write;
    grant1 = 1'b0;
    if (req1 && !req0) begin
      grant1 = 1'b1;
    end else if (req1 && req0) begin
      // lock wins contention; otherwise alternate away from the last winner
      grant1 = m1_lock | ~last_grant_q;
    end else begin
      grant1 = 1'b0;
    end
    grant0  = req0 & ~grant1;
    granted = grant0 | grant1;
    // a simultaneous read+write from the loader is a write and returns nothing
    rd_issue = grant0 | (grant1 & m1_read & ~m1_write);

    last_grant_d = granted ? grant1 : last_grant_q;
    rd_valid_d   = rd_issue;
    rd_owner_d   = granted ? grant1 : rd_owner_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    m0_waitrequest = reset | (req0 & ~grant0);
    m1_waitrequest = reset | (req1 & ~grant1);

    mem_clken      = ~reset;
    mem_chipselect = ~reset & granted;
    mem_write      = ~reset & grant1 & m1_write;
    mem_address    = grant1 ? m1_address : m0_address;
    mem_byteenable = (grant1 && m1_write) ? m1_byteenable : {BE_W{1'b1}};
    mem_writedata  = grant1 ? m1_writedata : {DATA_W{1'b0}};

    m0_readdatavalid = ~reset & rd_valid_q & ~rd_owner_q;
    m1_readdatavalid = ~reset & rd_valid_q & rd_owner_q;
    m0_readdata      = m0_readdatavalid ? mem_readdata : {DATA_W{1'b0}};
    m1_readdata      = m1_readdatavalid ? mem_readdata : {DATA_W{1'b0}};
  end

endmodule
